// File: rtl/anita_event_header_gen.sv
// rtl/anita_event_header_gen.sv - trigger snapshot FIFO, repeated SURF digitize commands and event header RAM writer
module anita_event_header_gen #(
    parameter int NBUF       = 4,
    parameter int NWORDS     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int EPOCH_BITS = 12,
    parameter int CMD_REPEAT = 2,
    parameter int GAP_CYCLES = 2,
    parameter int ADDR_BITS  = 6,
    localparam int BUF_BITS  = (NBUF > 1) ? $clog2(NBUF) : 1,
    localparam int PTR_BITS  = $clog2(FIFO_DEPTH),
    localparam int CNT_BITS  = PTR_BITS + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          trig_i,
    input  logic [BUF_BITS-1:0]           trig_buffer_i,
    input  logic [16*NWORDS-1:0]          trig_words_i,
    input  logic [EPOCH_BITS-1:0]         epoch_i,
    input  logic                          evid_reset_i,
    output logic                          cmd_start_o,
    output logic [BUF_BITS-1:0]           cmd_buffer_o,
    output logic [31:0]                   cmd_event_id_o,
    input  logic                          cmd_busy_i,
    input  logic                          cmd_done_i,
    output logic [BUF_BITS+ADDR_BITS-1:0] event_addr_o,
    output logic [15:0]                   event_dat_o,
    output logic                          event_wr_o,
    output logic                          event_done_o,
    output logic [31:0]                   next_id_o,
    output logic [CNT_BITS-1:0]           fifo_count_o,
    output logic                          overflow_o,
    output logic [15:0]                   dropped_o
);

    localparam int LOW_BITS  = 32 - EPOCH_BITS;
    localparam int WCNT_BITS = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [3:0] {
        IDLE, CMD_WAIT, CMD_RUN, CMD_GAP, ST_ID_LO, ST_ID_HI, ST_COUNT, ST_WORDS, DONE
    } state_t;

    state_t state, state_next;

    logic [BUF_BITS-1:0]  fifo_buf   [FIFO_DEPTH];
    logic [16*NWORDS-1:0] fifo_words [FIFO_DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]  count;
    logic                 full, push, pop;
    logic [BUF_BITS-1:0]  head_buf;
    logic [16*NWORDS-1:0] head_words;

    logic [2:0]           rep, rep_next;
    logic                 last_rep;
    logic [3:0]           gap;
    logic                 gap_end;
    logic [WCNT_BITS-1:0] widx;
    logic                 words_end;
    logic [15:0]          ev_count;
    logic [EPOCH_BITS-1:0] id_epoch;
    logic [LOW_BITS-1:0]  id_low;
    logic                 id_loaded;
    logic [31:0]          next_id;
    logic [BUF_BITS-1:0]  cmd_buffer;
    logic [31:0]          cmd_id;
    logic                 overflow;
    logic [15:0]          dropped;

    assign full       = (count == CNT_BITS'(FIFO_DEPTH));
    assign push       = trig_i && !full;
    assign pop        = (state == DONE);
    assign head_buf   = fifo_buf[rd_ptr];
    assign head_words = fifo_words[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_buf[wr_ptr]   <= trig_buffer_i;
            fifo_words[wr_ptr] <= trig_words_i;
        end
    end

    // A trigger arriving while full is dropped even if the head pops that cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            dropped  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
            if (push && !pop)      count <= count + CNT_BITS'(1);
            else if (!push && pop) count <= count - CNT_BITS'(1);
            if (trig_i && full) begin
                overflow <= 1'b1;
                if (dropped != 16'hFFFF) dropped <= dropped + 16'd1;
            end
        end
    end

    assign rep_next  = rep + 3'd1;
    assign last_rep  = (rep_next >= 3'(CMD_REPEAT));
    assign gap_end   = (gap == 4'(GAP_CYCLES - 1));
    assign words_end = (widx == WCNT_BITS'(NWORDS - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (count != '0) state_next = CMD_WAIT;
            CMD_WAIT: if (!cmd_busy_i) state_next = CMD_RUN;
            CMD_RUN:  if (cmd_done_i) begin
                          if (last_rep)             state_next = ST_ID_LO;
                          else if (GAP_CYCLES == 0) state_next = CMD_WAIT;
                          else                      state_next = CMD_GAP;
                      end
            CMD_GAP:  if (gap_end) state_next = CMD_WAIT;
            ST_ID_LO: state_next = ST_ID_HI;
            ST_ID_HI: state_next = ST_COUNT;
            ST_COUNT: state_next = ST_WORDS;
            ST_WORDS: if (words_end) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Until the first ID update the epoch field follows epoch_i live, so reset reads as {epoch_i, 0}.
    assign next_id = {id_loaded ? id_epoch : epoch_i, id_low};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rep        <= '0;
            gap        <= '0;
            widx       <= '0;
            ev_count   <= '0;
            id_epoch   <= '0;
            id_low     <= '0;
            id_loaded  <= 1'b0;
            cmd_buffer <= '0;
            cmd_id     <= '0;
        end else begin
            if (state == IDLE && count != '0) begin
                ev_count   <= ev_count + 16'd1;
                rep        <= '0;
                cmd_buffer <= head_buf;
                cmd_id     <= next_id;
            end
            if (state == CMD_RUN && cmd_done_i) rep <= rep_next;
            gap  <= (state == CMD_GAP)  ? gap + 4'd1 : 4'd0;
            widx <= (state == ST_WORDS) ? widx + WCNT_BITS'(1) : '0;
            if (evid_reset_i) begin
                id_epoch  <= epoch_i;
                id_low    <= '0;
                id_loaded <= 1'b1;
            end else if (state == DONE) begin
                id_epoch  <= epoch_i;
                id_low    <= id_low + LOW_BITS'(1);
                id_loaded <= 1'b1;
            end
        end
    end

    always_comb begin
        cmd_start_o  = 1'b0;
        event_wr_o   = 1'b0;
        event_addr_o = '0;
        event_dat_o  = '0;
        event_done_o = 1'b0;
        case (state)
            CMD_WAIT: cmd_start_o = !cmd_busy_i;
            ST_ID_LO: begin
                event_wr_o   = 1'b1;
                event_addr_o = {head_buf, ADDR_BITS'(NWORDS)};
                event_dat_o  = cmd_id[15:0];
            end
            ST_ID_HI: begin
                event_wr_o   = 1'b1;
                event_addr_o = {head_buf, ADDR_BITS'(NWORDS + 1)};
                event_dat_o  = cmd_id[31:16];
            end
            ST_COUNT: begin
                event_wr_o   = 1'b1;
                event_addr_o = {head_buf, ADDR_BITS'(NWORDS + 2)};
                event_dat_o  = ev_count;
            end
            ST_WORDS: begin
                event_wr_o   = 1'b1;
                event_addr_o = {head_buf, ADDR_BITS'(widx)};
                event_dat_o  = head_words[16*widx +: 16];
            end
            DONE:     event_done_o = 1'b1;
            default:  ;
        endcase
    end

    assign cmd_buffer_o   = cmd_buffer;
    assign cmd_event_id_o = cmd_id;
    assign next_id_o      = next_id;
    assign fifo_count_o   = count;
    assign overflow_o     = overflow;
    assign dropped_o      = dropped;

endmodule

// File: tb/tb_anita_event_header_gen.sv
// tb/tb_anita_event_header_gen.sv - directed self-checking bench for anita_event_header_gen
module tb_anita_event_header_gen;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         trig_i;
    logic [1:0]   trig_buffer_i;
    logic [127:0] trig_words_i;
    logic [11:0]  epoch_i;
    logic         evid_reset_i;
    logic         cmd_start_o;
    logic [1:0]   cmd_buffer_o;
    logic [31:0]  cmd_event_id_o;
    logic         cmd_busy_i;
    logic         cmd_done_i;
    logic [7:0]   event_addr_o;
    logic [15:0]  event_dat_o;
    logic         event_wr_o;
    logic         event_done_o;
    logic [31:0]  next_id_o;
    logic [2:0]   fifo_count_o;
    logic         overflow_o;
    logic [15:0]  dropped_o;

    logic         w_trig;
    logic [0:0]   w_trig_buffer;
    logic [15:0]  w_words;
    logic [30:0]  w_epoch;
    logic         w_cmd_start;
    logic [0:0]   w_cmd_buffer;
    logic [31:0]  w_cmd_event_id;
    logic         w_cmd_done;
    logic [2:0]   w_event_addr;
    logic [15:0]  w_event_dat;
    logic         w_event_wr;
    logic         w_event_done;
    logic [31:0]  w_next_id;
    logic [1:0]   w_fifo_count;
    logic         w_overflow;
    logic [15:0]  w_dropped;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int w_ev_n   = 0;
    int t;
    logic resp_en = 1'b1;

    logic [31:0] wr_addr[$], wr_dat[$], wr_cyc[$];
    logic [31:0] st_cyc[$], st_buf[$], st_id[$];
    logic [31:0] dn_cyc[$], ev_cyc[$];

    anita_event_header_gen dut (
        .clk_i(clk), .rst_i(rst_i), .trig_i(trig_i), .trig_buffer_i(trig_buffer_i),
        .trig_words_i(trig_words_i), .epoch_i(epoch_i), .evid_reset_i(evid_reset_i),
        .cmd_start_o(cmd_start_o), .cmd_buffer_o(cmd_buffer_o), .cmd_event_id_o(cmd_event_id_o),
        .cmd_busy_i(cmd_busy_i), .cmd_done_i(cmd_done_i), .event_addr_o(event_addr_o),
        .event_dat_o(event_dat_o), .event_wr_o(event_wr_o), .event_done_o(event_done_o),
        .next_id_o(next_id_o), .fifo_count_o(fifo_count_o), .overflow_o(overflow_o),
        .dropped_o(dropped_o)
    );

    // Narrow-ID instance: one low ID bit so the low-field wrap is reachable.
    anita_event_header_gen #(
        .NBUF(2), .NWORDS(1), .FIFO_DEPTH(2), .EPOCH_BITS(31),
        .CMD_REPEAT(1), .GAP_CYCLES(0), .ADDR_BITS(2)
    ) u_wrap (
        .clk_i(clk), .rst_i(rst_i), .trig_i(w_trig), .trig_buffer_i(w_trig_buffer),
        .trig_words_i(w_words), .epoch_i(w_epoch), .evid_reset_i(1'b0),
        .cmd_start_o(w_cmd_start), .cmd_buffer_o(w_cmd_buffer), .cmd_event_id_o(w_cmd_event_id),
        .cmd_busy_i(1'b0), .cmd_done_i(w_cmd_done), .event_addr_o(w_event_addr),
        .event_dat_o(w_event_dat), .event_wr_o(w_event_wr), .event_done_o(w_event_done),
        .next_id_o(w_next_id), .fifo_count_o(w_fifo_count), .overflow_o(w_overflow),
        .dropped_o(w_dropped)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (event_wr_o) begin
            wr_addr.push_back(32'(event_addr_o));
            wr_dat.push_back(32'(event_dat_o));
            wr_cyc.push_back(cyc);
        end
        if (cmd_start_o) begin
            st_cyc.push_back(cyc);
            st_buf.push_back(32'(cmd_buffer_o));
            st_id.push_back(cmd_event_id_o);
        end
        if (cmd_done_i)   dn_cyc.push_back(cyc);
        if (event_done_o) ev_cyc.push_back(cyc);
        if (w_event_done) w_ev_n++;
    end

    initial begin
        cmd_done_i = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_start_o && resp_en) begin
                repeat (3) @(posedge clk);
                #1 cmd_done_i = 1'b1;
                @(posedge clk);
                #1 cmd_done_i = 1'b0;
            end
        end
    end

    initial begin
        w_cmd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (w_cmd_start) begin
                @(posedge clk);
                #1 w_cmd_done = 1'b1;
                @(posedge clk);
                #1 w_cmd_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [1:0] b, input logic [15:0] base);
        trig_buffer_i = b;
        for (int k = 0; k < 8; k++) trig_words_i[16*k +: 16] = base + 16'(k);
        trig_i = 1'b1;
        tick();
        trig_i = 1'b0;
    endtask

    task automatic wait_events(input int target);
        for (int n = 0; n < 3000 && ev_cyc.size() < target; n++) tick();
        check("event_done_timeout", 64'(ev_cyc.size() >= target), 1);
    endtask

    task automatic wait_done_state();
        for (int n = 0; n < 500 && !event_done_o; n++) tick();
        check("done_state_timeout", 64'(event_done_o), 1);
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_dat.delete(); wr_cyc.delete();
        st_cyc.delete(); st_buf.delete(); st_id.delete();
        dn_cyc.delete(); ev_cyc.delete();
    endtask

    task automatic check_event(input int base, input logic [1:0] b, input logic [31:0] id,
                               input logic [15:0] cnt, input logic [15:0] wbase);
        logic [7:0]  a;
        logic [15:0] d;
        if (wr_addr.size() < base + 11) begin
            check($sformatf("ev%0d_write_count", base / 11), 64'(wr_addr.size()), 64'(base + 11));
            return;
        end
        for (int j = 0; j < 11; j++) begin
            a = {b, 6'(j < 3 ? 8 + j : j - 3)};
            d = (j == 0) ? id[15:0] : (j == 1) ? id[31:16] : (j == 2) ? cnt : wbase + 16'(j - 3);
            check($sformatf("ev%0d_addr%0d", base / 11, j), wr_addr[base+j], a);
            check($sformatf("ev%0d_dat%0d", base / 11, j), wr_dat[base+j], d);
            if (j > 0) check($sformatf("ev%0d_cyc%0d", base / 11, j), wr_cyc[base+j], wr_cyc[base] + 32'(j));
        end
    endtask

    initial begin
        rst_i = 1'b1; trig_i = 1'b0; trig_buffer_i = '0; trig_words_i = '0;
        epoch_i = '0; evid_reset_i = 1'b0; cmd_busy_i = 1'b0;
        w_trig = 1'b0; w_trig_buffer = '0; w_words = 16'h00AA; w_epoch = 31'hABC;
        repeat (3) tick();

        // reset state
        check("rst_cmd_start", cmd_start_o, 0);
        check("rst_event_wr", event_wr_o, 0);
        check("rst_event_done", event_done_o, 0);
        check("rst_fifo_count", fifo_count_o, 0);
        check("rst_overflow", overflow_o, 0);
        check("rst_dropped", dropped_o, 0);
        check("rst_next_id", next_id_o, 0);
        check("rst_w_next_id", w_next_id, 32'h1578);
        rst_i = 1'b0;
        tick();

        // single event, two commands with gap
        t = cyc;
        trigger(2'd2, 16'h1000);
        wait_events(1);
        check("t1_starts", st_cyc.size(), 2);
        check("t1_dones", dn_cyc.size(), 2);
        if (st_cyc.size() >= 2 && dn_cyc.size() >= 2 && wr_cyc.size() >= 11) begin
            check("t1_latency", st_cyc[0], 32'(t + 2));
            check("t1_buf0", st_buf[0], 2);
            check("t1_buf1", st_buf[1], 2);
            check("t1_id0", st_id[0], 0);
            check("t1_gap", st_cyc[1] - dn_cyc[0], 3);
            check("t1_first_wr", wr_cyc[0], dn_cyc[1] + 1);
            check("t1_done_cyc", ev_cyc[0], wr_cyc[10] + 1);
        end
        check("t1_wr_total", wr_addr.size(), 11);
        check_event(0, 2'd2, 32'h0, 16'd1, 16'h1000);
        check("t1_next_id", next_id_o, 1);

        // busy held 10 cycles in CMD_WAIT
        cmd_busy_i = 1'b1;
        t = cyc;
        trigger(2'd1, 16'h2000);
        repeat (11) tick();
        check("t2_no_early_start", st_cyc.size(), 2);
        cmd_busy_i = 1'b0;
        wait_events(2);
        if (st_cyc.size() >= 3) begin
            check("t2_start_cyc", st_cyc[2], 32'(t + 12));
            check("t2_start_id", st_id[2], 1);
        end
        check_event(11, 2'd1, 32'h1, 16'd2, 16'h2000);
        check("t2_next_id", next_id_o, 2);

        // overflow: 6 triggers, depth 4, commands stalled
        rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
        clear_logs();
        cmd_busy_i = 1'b1;
        for (int e = 0; e < 6; e++) trigger(2'(e % 4), 16'h3000 + 16'(e * 16));
        tick();
        check("t3_fifo_full", fifo_count_o, 4);
        check("t3_overflow", overflow_o, 1);
        check("t3_dropped", dropped_o, 2);
        cmd_busy_i = 1'b0;
        wait_events(4);
        for (int e = 0; e < 4; e++) check_event(e * 11, 2'(e), 32'(e), 16'(e + 1), 16'h3000 + 16'(e * 16));
        check("t3_fifo_empty", fifo_count_o, 0);
        check("t3_dropped_hold", dropped_o, 2);

        // push and pop in the same cycle at count 3
        clear_logs();
        trigger(2'd1, 16'h4000);
        trigger(2'd2, 16'h4010);
        trigger(2'd3, 16'h4020);
        wait_done_state();
        check("t4_count_at_done", fifo_count_o, 3);
        trigger(2'd0, 16'h4030);
        check("t4_count_after", fifo_count_o, 3);
        wait_events(4);
        check_event(0,  2'd1, 32'd4, 16'd5, 16'h4000);
        check_event(11, 2'd2, 32'd5, 16'd6, 16'h4010);
        check_event(22, 2'd3, 32'd6, 16'd7, 16'h4020);
        check_event(33, 2'd0, 32'd7, 16'd8, 16'h4030);

        // evid_reset at DONE, then mid-event
        clear_logs();
        epoch_i = 12'hABC;
        trigger(2'd2, 16'h5000);
        wait_done_state();
        evid_reset_i = 1'b1; tick(); evid_reset_i = 1'b0;
        check("t5_reset_at_done", next_id_o, 32'hABC00000);
        check("t5_cmd_id_kept", cmd_event_id_o, 8);
        trigger(2'd1, 16'h5100);
        for (int n = 0; n < 500 && st_cyc.size() < 3; n++) tick();
        check("t5_start_seen", 64'(st_cyc.size() >= 3), 1);
        epoch_i = 12'h123;
        evid_reset_i = 1'b1; tick(); evid_reset_i = 1'b0;
        check("t5_mid_reset_id", next_id_o, 32'h12300000);
        wait_events(2);
        check_event(11, 2'd1, 32'hABC00000, 16'd10, 16'h5100);
        if (st_id.size() >= 4) check("t5_cmd_id_stable", st_id[3], 32'hABC00000);
        check("t5_next_id", next_id_o, 32'h12300001);

        // low ID field wrap on the narrow instance
        w_trig = 1'b1; tick(); w_trig = 1'b0;
        for (int n = 0; n < 200 && w_ev_n < 1; n++) tick();
        check("w_next_id_1", w_next_id, 32'h1579);
        w_trig = 1'b1; tick(); w_trig = 1'b0;
        for (int n = 0; n < 200 && w_ev_n < 2; n++) tick();
        check("w_next_id_wrap", w_next_id, 32'h1578);

        // reset during ST_WORDS
        epoch_i = '0;
        clear_logs();
        trigger(2'd3, 16'h6000);
        for (int n = 0; n < 500 && wr_addr.size() < 5; n++) tick();
        check("t6_writes_started", wr_addr.size(), 5);
        rst_i = 1'b1;
        #1;
        check("t6_event_wr", event_wr_o, 0);
        check("t6_event_addr", event_addr_o, 0);
        check("t6_event_dat", event_dat_o, 0);
        check("t6_cmd_start", cmd_start_o, 0);
        check("t6_event_done", event_done_o, 0);
        check("t6_fifo_count", fifo_count_o, 0);
        check("t6_overflow", overflow_o, 0);
        check("t6_dropped", dropped_o, 0);
        check("t6_cmd_buffer", cmd_buffer_o, 0);
        check("t6_cmd_id", cmd_event_id_o, 0);
        check("t6_next_id", next_id_o, 0);
        tick(); tick();
        rst_i = 1'b0;
        repeat (20) tick();
        check("t6_no_writes", wr_addr.size(), 5);
        clear_logs();
        trigger(2'd0, 16'h7000);
        wait_events(1);
        check_event(0, 2'd0, 32'h0, 16'd1, 16'h7000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
